// File: rtl/cnn_pkg.sv
// Shared CNN front-end parameters: image geometry, kernel size and the
// packing width of the vertical column handed from line_buffer to window_buffer.
package cnn_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int KERNEL_SIZE   = 5;
    localparam int IMG_WIDTH     = 28;
    localparam int IMG_HEIGHT    = 28;

    // Valid convolution positions per row seen by the window buffer.
    localparam int CONV_PER_LINE = IMG_WIDTH - KERNEL_SIZE + 1;

    // Width of one packed column (KERNEL_SIZE pixels, oldest row in the MSB byte).
    function automatic int col_bits(input int kernel_size, input int data_width);
        return kernel_size * data_width;
    endfunction

    localparam int COL_WIDTH = col_bits(KERNEL_SIZE, DATA_WIDTH);

endpackage

// File: rtl/line_row_mem.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// Contents are not reset; the consumer gates out rows that were never written.
module line_row_mem #(
    parameter int IMG_WIDTH  = 28,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];

    // Write the incoming pixel at its column; old value is still visible this cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[addr];

endmodule

// File: rtl/line_buffer.sv
// Streaming line buffer: keeps the previous KERNEL_SIZE-1 rows in rotating
// row slots and emits one KERNEL_SIZE-pixel vertical column per accepted
// pixel once enough rows are stored. Single output register, no skid buffer.
module line_buffer #(
    parameter int IMG_WIDTH   = cnn_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT  = cnn_pkg::IMG_HEIGHT,
    parameter int KERNEL_SIZE = cnn_pkg::KERNEL_SIZE,
    parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             pixel_in,
    input  logic                              valid_in,
    output logic                              ready_line,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_data_out,
    output logic                              valid_line_win,
    input  logic                              ready_win,
    output logic                              frame_done
);

    import cnn_pkg::*;

    localparam int COL_W = col_bits(KERNEL_SIZE, DATA_WIDTH);
    localparam int NSLOT = KERNEL_SIZE - 1;
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [XW-1:0]         col_cnt_q, col_cnt_d;
    logic [YW-1:0]         row_cnt_q, row_cnt_d;
    logic [SW-1:0]         wr_slot_q, wr_slot_d;
    logic                  valid_q, valid_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  frame_done_q, frame_done_d;

    logic                  accept;
    logic                  load;
    logic                  col_last;
    logic                  row_last;
    logic [NSLOT-1:0]      wr_en;
    logic [DATA_WIDTH-1:0] rd_data [NSLOT];
    logic [COL_W-1:0]      col_next;

    assign ready_line     = !valid_q || ready_win;
    assign accept         = valid_in && ready_line;
    assign col_last       = (col_cnt_q == XW'(IMG_WIDTH - 1));
    assign row_last       = (row_cnt_q == YW'(IMG_HEIGHT - 1));
    // Rows 0..KERNEL_SIZE-2 only fill the slots; their columns are incomplete.
    assign load           = accept && (row_cnt_q >= YW'(KERNEL_SIZE - 1));

    assign col_data_out   = col_q;
    assign valid_line_win = valid_q;
    assign frame_done     = frame_done_q;

    for (genvar s = 0; s < NSLOT; s++) begin : g_row
        line_row_mem #(
            .IMG_WIDTH  (IMG_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_W     (XW)
        ) u_row (
            .clk     (clk),
            .wr_en   (wr_en[s]),
            .addr    (col_cnt_q),
            .wr_data (pixel_in),
            .rd_data (rd_data[s])
        );
    end

    // Only the slot holding the oldest row is overwritten by the new pixel.
    always_comb begin
        wr_en = '0;
        for (int s = 0; s < NSLOT; s++) begin
            wr_en[s] = accept && (wr_slot_q == SW'(s));
        end
    end

    // Rotate slots into age order: wr_slot is the oldest row, wr_slot+k is k rows newer.
    always_comb begin
        col_next = '0;
        col_next[DATA_WIDTH-1:0] = pixel_in;
        for (int k = 0; k < NSLOT; k++) begin
            for (int s = 0; s < NSLOT; s++) begin
                if (((int'(wr_slot_q) + k) % NSLOT) == s) begin
                    col_next[(KERNEL_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = rd_data[s];
                end
            end
        end
    end

    // Raster position and slot rotation advance only on an accepted pixel.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        wr_slot_d    = wr_slot_q;
        frame_done_d = 1'b0;
        if (accept) begin
            if (col_last) begin
                col_cnt_d = '0;
                if (row_last) begin
                    row_cnt_d    = '0;
                    wr_slot_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + YW'(1);
                    wr_slot_d = (wr_slot_q == SW'(NSLOT - 1)) ? '0 : wr_slot_q + SW'(1);
                end
            end else begin
                col_cnt_d = col_cnt_q + XW'(1);
            end
        end
    end

    // Output register: a new load wins over a drain, so back-to-back columns have no bubble.
    always_comb begin
        valid_d = valid_q;
        col_d   = col_q;
        if (load) begin
            valid_d = 1'b1;
            col_d   = col_next;
        end else if (ready_win) begin
            valid_d = 1'b0;
        end
    end

    // State update with synchronous active-low reset; row memory is left as is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            wr_slot_q    <= '0;
            valid_q      <= 1'b0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            wr_slot_q    <= wr_slot_d;
            valid_q      <= valid_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: full frames from a table of scenarios,
// columns predicted from an image model and matched through a queue.
module tb_line_buffer;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int K  = 5;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   pixel_in = '0;
    logic            valid_in = 1'b0;
    logic            ready_line;
    logic [K*DW-1:0] col_data_out;
    logic            valid_line_win;
    logic            ready_win = 1'b1;
    logic            frame_done;

    always #5 clk = ~clk;

    line_buffer #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_in       (pixel_in),
        .valid_in       (valid_in),
        .ready_line     (ready_line),
        .col_data_out   (col_data_out),
        .valid_line_win (valid_line_win),
        .ready_win      (ready_win),
        .frame_done     (frame_done)
    );

    typedef struct {
        int          mode;       // 0 ramp, 1 8'h80|col, 2 ramp with FF at (4,27),(5,0)
        bit          rbp;        // random ready_win
        int          hold_r;
        int          hold_c;
        int          rst_r;
        int          rst_c;
        logic [39:0] exp_first;
        int          exp_cols;
        int          exp_done;
    } tv_t;

    typedef struct {
        logic [39:0] col;
        int          r;
        int          c;
    } exp_t;

    tv_t         tv [6];
    exp_t        q [$];
    logic [7:0]  img [H][W];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ncols = 0;
    int          nfd = 0;
    int          t427 = -100;
    int          t50 = 0;
    logic [39:0] col50 = '0;
    logic [39:0] first_col = '0;
    bit          got_first = 1'b0;
    bit          in_reset = 1'b1;
    bit          rbp_now = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [39:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        logic [7:0] v;
        v = 8'(r + c);
        if (mode == 1) v = 8'h80 | 8'(c);
        if (mode == 2 && ((r == 4 && c == 27) || (r == 5 && c == 0))) v = 8'hFF;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: outputs sampled on the falling edge, between active edges.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (in_reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(valid_line_win), 64'd1);
                check("hold_data", 64'(col_data_out), 64'(prev_data));
            end
            if (frame_done) begin
                bit fd_ok;
                nfd++;
                fd_ok = 1'b0;
                if (valid_line_win && q.size() > 0) begin
                    fd_ok = (q[0].r == H - 1) && (q[0].c == W - 1);
                end
                check("frame_done_with_last_col", 64'(fd_ok), 64'd1);
            end
            if (valid_line_win && ready_win) begin
                ncols++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_col: got %0h want none", col_data_out);
                end else begin
                    e = q.pop_front();
                    check($sformatf("col(%0d,%0d)", e.r, e.c), 64'(col_data_out), 64'(e.col));
                    if (!got_first) begin
                        first_col = col_data_out;
                        got_first = 1'b1;
                    end
                    if (e.r == 4 && e.c == W - 1) t427 = cyc;
                    if (e.r == 5 && e.c == 0) begin
                        t50   = cyc;
                        col50 = col_data_out;
                    end
                end
            end
            prev_valid = valid_line_win;
            prev_ready = ready_win;
            prev_data  = col_data_out;
        end
    end

    task automatic clear_run_stats();
        ncols     = 0;
        nfd       = 0;
        got_first = 1'b0;
        first_col = '0;
        t427      = -100;
        t50       = 0;
        col50     = '0;
    endtask

    // Drive one pixel until it is accepted; predicted column queued at the accept.
    task automatic send_px(input logic [7:0] v, input int r, input int c);
        bit acc;
        acc = 1'b0;
        pixel_in = v;
        valid_in = 1'b1;
        for (int t = 0; t < 200; t++) begin
            exp_t e;
            @(negedge clk);
            acc = ready_line;
            if (acc && r >= K - 1) begin
                e.col = {img[r-4][c], img[r-3][c], img[r-2][c], img[r-1][c], v};
                e.r   = r;
                e.c   = c;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            ready_win = rbp_now ? 1'($urandom_range(0, 1)) : 1'b1;
            if (acc) break;
        end
        check($sformatf("accept_timeout(%0d,%0d)", r, c), 64'(acc), 64'd1);
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        q.delete();
        valid_in = 1'b0;
        ready_win = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_valid", 64'(valid_line_win), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_ready_line", 64'(ready_line), 64'd1);
        clear_run_stats();
        in_reset = 1'b0;
    endtask

    task automatic do_hold();
        ready_win = 1'b0;
        pixel_in  = 8'hEE;
        for (int i = 0; i < 6; i++) begin
            valid_in = (i % 2 == 0);
            @(negedge clk);
            check("bp_ready_line", 64'(ready_line), 64'd0);
            check("bp_valid", 64'(valid_line_win), 64'd1);
            @(posedge clk);
            #1;
        end
        valid_in  = 1'b0;
        ready_win = 1'b1;
    endtask

    task automatic run_frame(input int e);
        int  y;
        int  x;
        bit  did_reset;
        logic [7:0] v;
        y = 0;
        x = 0;
        did_reset = 1'b0;
        rbp_now = tv[e].rbp;
        ready_win = 1'b1;
        clear_run_stats();
        while (y < H) begin
            if (!did_reset && y == tv[e].rst_r && x == tv[e].rst_c) begin
                do_reset();
                did_reset = 1'b1;
                y = 0;
                x = 0;
            end else begin
                v = pix(tv[e].mode, y, x);
                img[y][x] = v;
                send_px(v, y, x);
                if (y == tv[e].hold_r && x == tv[e].hold_c) do_hold();
                x++;
                if (x == W) begin
                    x = 0;
                    y++;
                end
            end
        end
        valid_in  = 1'b0;
        rbp_now   = 1'b0;
        ready_win = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("drain_empty[%0d]", e), 64'(q.size()), 64'd0);
        check($sformatf("col_count[%0d]", e), 64'(ncols), 64'(tv[e].exp_cols));
        check($sformatf("frame_done_count[%0d]", e), 64'(nfd), 64'(tv[e].exp_done));
        check($sformatf("first_col[%0d]", e), 64'(first_col), 64'(tv[e].exp_first));
        if (tv[e].mode == 2) begin
            check("row_boundary_back_to_back", 64'(t50 - t427), 64'd1);
            check("col_5_0", 64'(col50), 64'h01_02_03_04_FF);
        end
    endtask

    initial begin
        tv[0] = '{mode:0, rbp:0, hold_r:-1, hold_c:-1, rst_r:-1, rst_c:-1,
                  exp_first:40'h00_01_02_03_04, exp_cols:672, exp_done:1};
        tv[1] = '{mode:0, rbp:1, hold_r:-1, hold_c:-1, rst_r:-1, rst_c:-1,
                  exp_first:40'h00_01_02_03_04, exp_cols:672, exp_done:1};
        tv[2] = '{mode:1, rbp:0, hold_r:-1, hold_c:-1, rst_r:-1, rst_c:-1,
                  exp_first:40'h80_80_80_80_80, exp_cols:672, exp_done:1};
        tv[3] = '{mode:2, rbp:0, hold_r:-1, hold_c:-1, rst_r:-1, rst_c:-1,
                  exp_first:40'h00_01_02_03_04, exp_cols:672, exp_done:1};
        tv[4] = '{mode:0, rbp:0, hold_r:4, hold_c:0, rst_r:-1, rst_c:-1,
                  exp_first:40'h00_01_02_03_04, exp_cols:672, exp_done:1};
        tv[5] = '{mode:0, rbp:0, hold_r:-1, hold_c:-1, rst_r:10, rst_c:12,
                  exp_first:40'h00_01_02_03_04, exp_cols:672, exp_done:1};

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready_line", 64'(ready_line), 64'd1);
        check("reset_valid", 64'(valid_line_win), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_col_data", 64'(col_data_out), 64'd0);
        rst_n = 1'b1;
        in_reset = 1'b0;

        for (int e = 0; e < 6; e++) begin
            run_frame(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buffer.md
# line_buffer

Streaming line buffer feeding the 5×5 window buffer. It accepts one 8-bit pixel per cycle in raster order and stores the previous KERNEL_SIZE−1 image rows. Once enough rows are buffered, it emits one KERNEL_SIZE-pixel vertical column per accepted pixel over the valid_line_win/ready_win handshake. It is the transmitting end of the line→window column interface and sits between the image input stream and window_buffer.

## Interface
- IMG_WIDTH, 28, pixels per row (columns emitted per row)
- IMG_HEIGHT, 28, rows per frame
- KERNEL_SIZE, 5, column height in pixels
- DATA_WIDTH, 8, pixel width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pixel_in  in  DATA_WIDTH  input pixel, raster order
- valid_in  in  1  pixel_in valid
- ready_line  out  1  block can accept pixel this cycle
- col_data_out  out  KERNEL_SIZE*DATA_WIDTH  column to window buffer; MSB byte = oldest row (y−4), LSB byte = current row y
- valid_line_win  out  1  col_data_out valid
- ready_win  in  1  window buffer accepts column
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted

## Operation
- Accept: pixel accepted when valid_in && ready_line; ready_line = !valid_line_win || ready_win (single output register, no skid).
- Counters: col_cnt 0..IMG_WIDTH−1, row_cnt 0..IMG_HEIGHT−1; advance only on accept. col_cnt wraps at IMG_WIDTH−1 and increments row_cnt. At (IMG_HEIGHT−1, IMG_WIDTH−1) both wrap to 0, and frame_done pulses.
- Storage: KERNEL_SIZE−1 row slots of IMG_WIDTH×DATA_WIDTH. wr_slot (0..KERNEL_SIZE−2) advances when a row completes and wraps at end of frame to 0.
- On an accepted pixel at (row y, col x), read all slots at x (pre-write values). Slot wr_slot holds row y−4; slots wr_slot+1, +2, +3 (mod 4) hold rows y−3..y−1. Write pixel_in into slot wr_slot at x in the same edge.
- Output load: if row_cnt ≥ KERNEL_SIZE−1, col_data_out ← {row y−4 .. row y−1, pixel_in} and valid_line_win ← 1. Rows 0..3 produce no output.
- Output drain: valid_line_win clears when ready_win && !(new load this cycle).
- Per frame: (IMG_HEIGHT−4)×IMG_WIDTH = 672 columns at defaults. The window buffer derives IMG_WIDTH−KERNEL_SIZE+1 = 24 convolutions per row from these columns.

## Timing
- Reset (rst_n=0 at edge): col_cnt=0, row_cnt=0, wr_slot=0, valid_line_win=0, col_data_out=0, frame_done=0. Row memory is not cleared and is don't-care, because rows 0..3 are gated.
- ready_line is combinational from valid_line_win and ready_win, and is 1 after reset.
- Latency: accepted pixel at edge N → valid_line_win=1 with its column after edge N. 1 cycle.
- Throughput: 1 column/cycle when ready_win held high. Simultaneous drain and load is allowed with no bubble.
- Backpressure: valid_line_win=1 && ready_win=0 → ready_line=0; col_data_out and valid_line_win hold stable; counters frozen.
- Row boundary: a column at x=IMG_WIDTH−1 and the next column at x=0 of row y+1 are back-to-back. wr_slot advances on the same edge as the row wrap.
- frame_done: asserted the cycle after the final accept, concurrent with the final column's valid. It is not held under backpressure.
- Reset mid-frame: next accepted pixel is treated as (0,0); any pending column is discarded.

## Structure
- Shared package cnn_pkg: DATA_WIDTH, KERNEL_SIZE, IMG_WIDTH, IMG_HEIGHT defaults; derived CONV_PER_LINE = IMG_WIDTH−KERNEL_SIZE+1; column packing width KERNEL_SIZE*DATA_WIDTH.
- Sub-module line_row_mem: one IMG_WIDTH×DATA_WIDTH row with async read and sync write-enable. Instantiate KERNEL_SIZE−1 times.
- Top holds the counters, slot rotation mux, output register and handshake.

## Test plan
- Reset then stream 28×28 pixels with pixel = (row+col) & 0xFF and ready_win=1 → first valid after pixel (4,0). Column at (4,0) = {00,01,02,03,04}; exactly 672 valid columns; frame_done one pulse.
- Random ready_win (50%) over full frame → column values identical to the no-backpressure run; col_data_out stable while valid && !ready_win; no column lost or duplicated.
- Row boundary: pixel (4,27) then (5,0) with value 8'hFF → columns back-to-back on consecutive cycles. Column (5,0) MSB byte = pixel (1,0).
- Two consecutive frames, frame 2 pixel = 8'h80|col → frame-2 column (4,0) = {80,80,80,80,80}, with no frame-1 data.
- Hold ready_win=0 with valid pending → ready_line=0, valid_in pulses ignored, col_cnt unchanged.
- Assert rst_n=0 for one cycle at pixel (10,12) → valid_line_win=0 next cycle; next output only after 4 full rows plus one pixel are re-accepted.
